dmem_responder: RTL and testbench

Data-memory responder for the LC3 pipeline: the memory-side end of the MEM-stage data interface. It accepts read/write requests from the memory-access stage, services them from an internal word array after a parameterised number of wait cycles, and signals completion with a one-cycle ready pulse. The stage controller stalls on this ready pulse, so memory latency can vary without changing pipeline RTL.

---
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: services MEM-stage reads/writes from an internal word array.
// Latency: LATENCY cycles from accept to the DMem_ready pulse; back-to-back every LATENCY+1 cycles.
// Backpressure: none buffered; requests are sampled only in IDLE/DONE, and BUSY ignores all inputs.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DMem_en,
    input  logic        DMem_rd,
    input  logic [15:0] DMem_addr,
    input  logic [15:0] DMem_din,
    output logic [15:0] DMem_dout,
    output logic        DMem_ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (ADDR_W < 16) begin : g_alias
            // Upper address bits are deliberately dropped, so the array aliases.
            logic addr_unused;
            assign addr_unused = ^DMem_addr[15:ADDR_W];
        end
    endgenerate

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_rd;
    logic [15:0]       req_din;
    logic [15:0]       dout_q;
    logic [15:0]       mem [0:DEPTH-1];
    logic              mem_we;

    // Write commits on the same edge that moves BUSY to DONE, so a following read sees it.
    assign mem_we = (state == S_BUSY) && (cnt == 4'd0) && !req_rd;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[req_addr] <= req_din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            req_addr <= '0;
            req_rd   <= 1'b0;
            req_din  <= 16'h0000;
            dout_q   <= 16'h0000;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (DMem_en) begin
                        req_addr <= DMem_addr[ADDR_W-1:0];
                        req_rd   <= DMem_rd;
                        req_din  <= DMem_din;
                        cnt      <= CNT_INIT;
                        state    <= S_BUSY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (req_rd) begin
                            dout_q <= mem[req_addr];
                        end
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign DMem_ready = (state == S_DONE);
    assign DMem_dout  = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=3 instance for the main vectors and a
// LATENCY=1 instance for the minimum-latency boundary; a negedge monitor checks every cycle.
module tb_dmem_responder;

    localparam int L0 = 3;
    localparam int L1 = 1;

    typedef struct {
        logic        rd;
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en0 = 1'b0, rd0 = 1'b0, en1 = 1'b0, rd1 = 1'b0;
    logic [15:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0;
    logic [15:0] dout0, dout1;
    logic        rdy0, rdy1;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] held0 = 16'h0000;
    logic [15:0] held1 = 16'h0000;

    dmem_responder #(.ADDR_W(10), .LATENCY(L0)) u_dut (
        .clock(clock), .reset(reset), .DMem_en(en0), .DMem_rd(rd0),
        .DMem_addr(addr0), .DMem_din(din0), .DMem_dout(dout0), .DMem_ready(rdy0)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(L1)) u_dut1 (
        .clock(clock), .reset(reset), .DMem_en(en1), .DMem_rd(rd1),
        .DMem_addr(addr1), .DMem_din(din1), .DMem_dout(dout1), .DMem_ready(rdy1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_port(input bit sel, input logic rdy, input logic [15:0] dout);
        exp_t        e;
        logic [15:0] held;
        logic [15:0] want;
        held = sel ? held1 : held0;
        if (!reset) begin
            n_chk++;
            if (rdy !== 1'b0 || dout !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_state[%0d] ready=%b dout=%h, required ready=0 dout=0000", sel, rdy, dout);
            end
            held = 16'h0000;
        end else begin
            // A scheduled completion that has already passed without a pulse is lost.
            while ((sel ? q1.size() : q0.size()) > 0 && (sel ? q1[0].cyc : q0[0].cyc) < cyc) begin
                e = sel ? q1.pop_front() : q0.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missing_ready[%0d] expected at cycle %0d, still absent at cycle %0d", sel, e.cyc, cyc);
            end
            if (rdy === 1'b1) begin
                if ((sel ? q1.size() : q0.size()) == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_ready[%0d] at cycle %0d, required no pulse", sel, cyc);
                end else begin
                    e = sel ? q1.pop_front() : q0.pop_front();
                    n_chk++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL ready_time[%0d] pulse at cycle %0d, required %0d", sel, cyc, e.cyc);
                    end
                    want = e.rd ? e.dat : held;
                    n_chk++;
                    if (dout !== want) begin
                        n_fail++;
                        $display("FAIL done_dout[%0d] rd=%b dout=%h, required %h", sel, e.rd, dout, want);
                    end
                    if (e.rd) held = e.dat;
                end
            end else begin
                n_chk++;
                if (rdy !== 1'b0 || dout !== held) begin
                    n_fail++;
                    $display("FAIL idle_hold[%0d] ready=%b dout=%h, required ready=0 dout=%h", sel, rdy, dout, held);
                end
            end
        end
        if (sel) held1 = held; else held0 = held;
    endtask

    always @(negedge clock) begin
        check_port(1'b0, rdy0, dout0);
        check_port(1'b1, rdy1, dout1);
    end

    task automatic drive(input bit sel, input logic en, input logic rd,
                         input logic [15:0] addr, input logic [15:0] din);
        if (sel) begin en1 = en; rd1 = rd; addr1 = addr; din1 = din; end
        else     begin en0 = en; rd0 = rd; addr0 = addr; din0 = din; end
    endtask

    // Called just after a negedge while the DUT is IDLE or DONE; returns at the DONE-cycle negedge.
    task automatic req(input bit sel, input logic rd, input logic [15:0] addr,
                       input logic [15:0] din, input logic [15:0] exp_dat, input bit disturb);
        exp_t e;
        int   lat;
        lat = sel ? L1 : L0;
        drive(sel, 1'b1, rd, addr, din);
        @(posedge clock);
        #1;
        e.rd = rd; e.dat = exp_dat; e.cyc = cyc + lat;
        if (sel) q1.push_back(e); else q0.push_back(e);
        for (int i = 0; i < lat; i++) begin
            @(negedge clock);
            if (disturb) drive(sel, i[0], ~rd, 16'hxxxx, 16'hzzzz);
            else         drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // Reset held with inputs toggling, then released with DMem_en low.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            drive(1'b0, i[0], ~i[1], 16'(i * 16'h0101), 16'hF0F0 ^ 16'(i));
            drive(1'b1, ~i[0], i[1], 16'(i), 16'(i));
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        idle(20);

        // Write then read; dout untouched by writes.
        req(1'b0, 1'b0, 16'h0042, 16'hBEEF, 16'h0000, 1'b0);
        idle(2);
        req(1'b0, 1'b1, 16'h0042, 16'h0000, 16'hBEEF, 1'b0);
        idle(3);
        req(1'b0, 1'b0, 16'h0043, 16'h1234, 16'h0000, 1'b0);
        idle(2);

        // Back-to-back writes then back-to-back reads.
        req(1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0000, 1'b0);
        req(1'b0, 1'b0, 16'h0001, 16'h2222, 16'h0000, 1'b0);
        req(1'b0, 1'b0, 16'h0002, 16'h3333, 16'h0000, 1'b0);
        req(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1111, 1'b0);
        req(1'b0, 1'b1, 16'h0001, 16'h0000, 16'h2222, 1'b0);
        req(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h3333, 1'b0);
        idle(2);

        // Address aliasing above ADDR_W bits.
        req(1'b0, 1'b0, 16'h0405, 16'hA5A5, 16'h0000, 1'b0);
        idle(1);
        req(1'b0, 1'b1, 16'h0005, 16'h0000, 16'hA5A5, 1'b0);
        req(1'b0, 1'b1, 16'hFC05, 16'h0000, 16'hA5A5, 1'b0);
        req(1'b0, 1'b1, 16'h0043, 16'h0000, 16'h1234, 1'b0);
        idle(2);

        // Read-after-write, back-to-back, same address.
        req(1'b0, 1'b0, 16'h0020, 16'hCAFE, 16'h0000, 1'b0);
        req(1'b0, 1'b1, 16'h0020, 16'h0000, 16'hCAFE, 1'b0);
        idle(2);

        // Inputs disturbed during BUSY must not affect the captured request.
        req(1'b0, 1'b0, 16'h0010, 16'h5A5A, 16'h0000, 1'b1);
        idle(1);
        req(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5A5A, 1'b1);
        idle(2);

        // Minimum latency instance: write, back-to-back read, isolated read.
        req(1'b1, 1'b0, 16'h0003, 16'h9999, 16'h0000, 1'b0);
        req(1'b1, 1'b1, 16'h0003, 16'h0000, 16'h9999, 1'b0);
        idle(2);
        req(1'b1, 1'b1, 16'h0000, 16'h0000, 16'hxxxx, 1'b0);
        idle(1);
        q1.delete();
        held1 = dout1;
        req(1'b1, 1'b1, 16'h0003, 16'h0000, 16'h9999, 1'b0);
        idle(2);

        // Reset two cycles into a write drops it; release with DMem_en high accepts at once.
        req(1'b0, 1'b0, 16'h0008, 16'h0001, 16'h0000, 1'b0);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 16'h0008, 16'h7777);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(2);
        drive(1'b0, 1'b1, 1'b1, 16'h0008, 16'h0000);
        idle(1);
        reset = 1'b1;
        req(1'b0, 1'b1, 16'h0008, 16'h0000, 16'h0001, 1'b0);
        idle(6);

        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d/%0d, required 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
